// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU definitions for the fetch stage: reset PC, next-PC source
// encoding, instruction field widths and the beq offset helper.
package fetch_pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          INSTR_W          = 32;
    localparam int          IMM16_W          = 16;
    localparam int          INDEX26_W        = 26;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_src_t;

    // Sign-extended, word-scaled beq displacement.
    function automatic logic signed [31:0] br_offset(input logic [IMM16_W-1:0] imm);
        return {{(32 - IMM16_W - 2){imm[IMM16_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_pc_unit_if
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit_npc_calc.sv
// Redirect target selection for the instruction held in ID (jr > j > beq).
module npc_calc
    import fetch_pc_unit_pkg::*;
(
    input  logic                 stall,
    input  logic                 br_en,
    input  logic                 j_op,
    input  logic                 j_en,
    input  logic                 jr_en,
    input  logic [IMM16_W-1:0]   br_imm,
    input  logic [INDEX26_W-1:0] j_index,
    input  logic [31:0]          jr_target,
    input  logic [31:0]          id_pc,
    output logic [31:0]          delay_slot_pc,
    output logic [31:0]          target,
    output logic                 redirect
);

    npc_src_t           src;
    logic signed [31:0] br_target_s;

    // Prioritised source select and target formation; beq wraps at 32 bits.
    always_comb begin
        delay_slot_pc = id_pc + 32'd4;
        br_target_s   = $signed(delay_slot_pc) + br_offset(br_imm);
        src           = NPC_SEQ;
        if (jr_en)
            src = NPC_JR;
        else if (j_en)
            src = NPC_J;
        else if (br_en && j_op)
            src = NPC_BR;

        unique case (src)
            NPC_JR:  target = jr_target;
            NPC_J:   target = {id_pc[31:28], j_index, 2'b00};
            NPC_BR:  target = $unsigned(br_target_s);
            default: target = delay_slot_pc;
        endcase

        redirect = ~stall && (src != NPC_SEQ);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC and fetch controller: req/ack fetch into a one-entry IF/ID
// buffer, with single-delay-slot redirects from ID.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          IMEM_ADDR_W = 32
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 br_en,
    input  logic                 j_op,
    input  logic [IMM16_W-1:0]   br_imm,
    input  logic                 j_en,
    input  logic [INDEX26_W-1:0] j_index,
    input  logic                 jr_en,
    input  logic [31:0]          jr_target,
    input  logic [31:0]          id_pc,
    fetch_pc_unit_if.master      imem,
    output logic                 if_valid,
    output logic [31:0]          if_pc,
    output logic [INSTR_W-1:0]   if_instr
);

    logic [31:0] pc;
    logic [31:0] pending_target;
    logic        pending_valid;
    logic        squash;

    logic [31:0] target;
    logic [31:0] delay_slot_pc;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic        in_delay_slot;
    logic        consume;
    logic        req;
    logic        ack_ok;
    logic        discard;
    logic        accept;

    npc_calc u_npc_calc (
        .stall         (stall),
        .br_en         (br_en),
        .j_op          (j_op),
        .j_en          (j_en),
        .jr_en         (jr_en),
        .br_imm        (br_imm),
        .j_index       (j_index),
        .jr_target     (jr_target),
        .id_pc         (id_pc),
        .delay_slot_pc (delay_slot_pc),
        .target        (target),
        .redirect      (redirect)
    );

    // Handshake qualification; a redirect while pc is past the delay slot
    // means the current fetch is wrong-path and its data must be dropped.
    always_comb begin
        consume       = if_valid & ~stall;
        req           = reset & ~(if_valid & stall);
        in_delay_slot = (pc == delay_slot_pc);
        ack_ok        = imem.imem_ack & req;
        discard       = squash | (redirect & ~in_delay_slot);
        accept        = ack_ok & ~discard;
        seq_pc        = pending_valid ? pending_target : pc + 32'd4;
        next_pc       = (redirect & in_delay_slot) ? target : seq_pc;
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc[IMEM_ADDR_W-1:0];

    // PC, IF/ID buffer and redirect bookkeeping; pc is held during a squash
    // so the outstanding address stays stable until its ack arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_PC;
            if_valid      <= 1'b0;
            if_pc         <= '0;
            if_instr      <= '0;
            pending_valid <= 1'b0;
            squash        <= 1'b0;
        end else if (accept) begin
            if_valid      <= 1'b1;
            if_pc         <= pc;
            if_instr      <= imem.imem_rdata;
            pc            <= next_pc;
            pending_valid <= 1'b0;
        end else begin
            if (consume)
                if_valid <= 1'b0;
            if (ack_ok) begin
                squash <= 1'b0;
                pc     <= (redirect & ~in_delay_slot) ? target : pending_target;
            end else if (redirect) begin
                if (in_delay_slot)
                    pending_valid <= 1'b1;
                else
                    squash <= 1'b1;
            end
        end
    end

    // Deferred redirect target, captured whenever a redirect cannot act now.
    always_ff @(posedge clk) begin
        if (redirect && !ack_ok)
            pending_target <= target;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, stall hold, beq/j/jr
// redirects with delay slot, deferred redirect, stalled redirect, mid-fetch reset.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_en;
    logic        j_op;
    logic [15:0] br_imm;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] id_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        ack_mode;

    int tests = 0;
    int fails = 0;

    fetch_pc_unit_if #(.ADDR_W(32)) imem_bus ();

    // Memory model: instruction word is 0xCAFE in the upper half, address below.
    assign imem_bus.imem_ack   = ack_mode & imem_bus.imem_req;
    assign imem_bus.imem_rdata = {16'hCAFE, imem_bus.imem_addr[15:0]};

    fetch_pc_unit #(.RESET_PC(32'h0000_3000), .IMEM_ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_en     (br_en),
        .j_op      (j_op),
        .br_imm    (br_imm),
        .j_en      (j_en),
        .j_index   (j_index),
        .jr_en     (jr_en),
        .jr_target (jr_target),
        .id_pc     (id_pc),
        .imem      (imem_bus),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        br_en = 0; j_op = 0; br_imm = '0; j_en = 0; j_index = '0;
        jr_en = 0; jr_target = '0; id_pc = '0;
    endtask

    task automatic test_reset();
        reset = 0; stall = 0; ack_mode = 1; clear_id();
        tick(); tick();
        tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", imem_bus.imem_req); end
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", if_valid); end
        tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL rst_if_pc got %h want 0", if_pc); end
        tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL rst_if_instr got %h want 0", if_instr); end
        tests++; if (imem_bus.imem_addr !== 32'h3000) begin fails++; $display("FAIL rst_addr got %h want 3000", imem_bus.imem_addr); end
        #3 reset = 1;
        #1;
        tests++; if (imem_bus.imem_req !== 1'b1) begin fails++; $display("FAIL rel_req got %b want 1", imem_bus.imem_req); end
    endtask

    task automatic test_sequential();
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3000) begin fails++; $display("FAIL seq0 valid=%b pc=%h want 1/3000", if_valid, if_pc); end
        tests++; if (imem_bus.imem_addr !== 32'h3004) begin fails++; $display("FAIL seq0_addr got %h want 3004", imem_bus.imem_addr); end
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3004) begin fails++; $display("FAIL seq1 valid=%b pc=%h want 1/3004", if_valid, if_pc); end
        tests++; if (imem_bus.imem_addr !== 32'h3008) begin fails++; $display("FAIL seq1_addr got %h want 3008", imem_bus.imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h3008 || if_instr !== 32'hCAFE3008) begin fails++; $display("FAIL seq2 pc=%h instr=%h want 3008/cafe3008", if_pc, if_instr); end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #0;
            tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_bus.imem_req); end
            tick();
            tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3008 || if_instr !== 32'hCAFE3008) begin
                fails++; $display("FAIL stall_hold[%0d] valid=%b pc=%h instr=%h want 1/3008/cafe3008", i, if_valid, if_pc, if_instr); end
        end
        stall = 0;
        tick();
        tests++; if (if_pc !== 32'h300C || imem_bus.imem_addr !== 32'h3010) begin fails++; $display("FAIL stall_resume pc=%h addr=%h want 300c/3010", if_pc, imem_bus.imem_addr); end
    endtask

    task automatic test_beq_taken();
        tick();
        br_en = 1; j_op = 1; br_imm = 16'hFFFC; id_pc = 32'h3010;
        tick();
        clear_id();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3014) begin fails++; $display("FAIL beq_ds valid=%b pc=%h want 1/3014", if_valid, if_pc); end
        // 0x3014 + (-4 << 2) = 0x3004
        tests++; if (imem_bus.imem_addr !== 32'h3004) begin fails++; $display("FAIL beq_target got %h want 3004", imem_bus.imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h3004 || imem_bus.imem_addr !== 32'h3008) begin fails++; $display("FAIL beq_after pc=%h addr=%h want 3004/3008", if_pc, imem_bus.imem_addr); end
    endtask

    task automatic test_beq_not_taken();
        tick(); tick(); tick();
        br_en = 1; j_op = 0; br_imm = 16'hFFFC; id_pc = 32'h3010;
        tick();
        clear_id();
        tests++; if (if_pc !== 32'h3014 || imem_bus.imem_addr !== 32'h3018) begin fails++; $display("FAIL beq_nt pc=%h addr=%h want 3014/3018", if_pc, imem_bus.imem_addr); end
    endtask

    task automatic test_jump();
        tick(); tick(); tick();
        j_en = 1; id_pc = 32'h3020; j_index = 26'h0000C40;
        tick();
        clear_id();
        tests++; if (if_pc !== 32'h3024 || imem_bus.imem_addr !== 32'h3100) begin fails++; $display("FAIL j_ds pc=%h addr=%h want 3024/3100", if_pc, imem_bus.imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h3100 || if_instr !== 32'hCAFE3100) begin fails++; $display("FAIL j_target pc=%h instr=%h want 3100/cafe3100", if_pc, if_instr); end
    endtask

    task automatic test_jr_squash();
        // steer back to 0x301C so the jr scenario runs at 0x3020
        j_en = 1; id_pc = 32'h3100; j_index = 26'h0000C07;
        tick();
        clear_id();
        tick(); tick(); tick();
        tests++; if (if_pc !== 32'h3024 || imem_bus.imem_addr !== 32'h3028) begin fails++; $display("FAIL jr_setup pc=%h addr=%h want 3024/3028", if_pc, imem_bus.imem_addr); end
        ack_mode = 0;
        jr_en = 1; jr_target = 32'h3400; id_pc = 32'h3020;
        tick();
        clear_id();
        tests++; if (if_valid !== 1'b0 || imem_bus.imem_addr !== 32'h3028) begin fails++; $display("FAIL jr_hold valid=%b addr=%h want 0/3028", if_valid, imem_bus.imem_addr); end
        tick();
        tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3028) begin fails++; $display("FAIL jr_stable req=%b addr=%h want 1/3028", imem_bus.imem_req, imem_bus.imem_addr); end
        ack_mode = 1;
        tick();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL jr_discard valid got %b want 0", if_valid); end
        tests++; if (imem_bus.imem_addr !== 32'h3400) begin fails++; $display("FAIL jr_target got %h want 3400", imem_bus.imem_addr); end
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3400 || if_instr !== 32'hCAFE3400) begin
            fails++; $display("FAIL jr_fetch valid=%b pc=%h instr=%h want 1/3400/cafe3400", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_pending();
        ack_mode = 0;
        j_en = 1; id_pc = 32'h3400; j_index = 26'h0000C40;
        tick();
        clear_id();
        tests++; if (if_valid !== 1'b0 || imem_bus.imem_addr !== 32'h3404) begin fails++; $display("FAIL pend_hold valid=%b addr=%h want 0/3404", if_valid, imem_bus.imem_addr); end
        tick();
        ack_mode = 1;
        tick();
        tests++; if (if_pc !== 32'h3404 || imem_bus.imem_addr !== 32'h3100) begin fails++; $display("FAIL pend_ds pc=%h addr=%h want 3404/3100", if_pc, imem_bus.imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h3100 || imem_bus.imem_addr !== 32'h3104) begin fails++; $display("FAIL pend_clear pc=%h addr=%h want 3100/3104", if_pc, imem_bus.imem_addr); end
    endtask

    task automatic test_stall_redirect();
        // redirect seen only while stalled, then withdrawn: must be ignored
        j_en = 1; id_pc = 32'h3100; j_index = 26'h0000C80; stall = 1;
        tick();
        tests++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h3104 || if_pc !== 32'h3100) begin
            fails++; $display("FAIL stl_rd1 req=%b addr=%h pc=%h want 0/3104/3100", imem_bus.imem_req, imem_bus.imem_addr, if_pc); end
        clear_id(); stall = 0;
        tick();
        tests++; if (if_pc !== 32'h3104 || imem_bus.imem_addr !== 32'h3108) begin fails++; $display("FAIL stl_ignored pc=%h addr=%h want 3104/3108", if_pc, imem_bus.imem_addr); end
        // redirect re-presented after stall drops: taken then
        j_en = 1; id_pc = 32'h3104; j_index = 26'h0000C80; stall = 1;
        tick();
        tests++; if (imem_bus.imem_addr !== 32'h3108 || if_pc !== 32'h3104) begin fails++; $display("FAIL stl_rd2 addr=%h pc=%h want 3108/3104", imem_bus.imem_addr, if_pc); end
        stall = 0;
        tick();
        clear_id();
        tests++; if (if_pc !== 32'h3108 || imem_bus.imem_addr !== 32'h3200) begin fails++; $display("FAIL stl_taken pc=%h addr=%h want 3108/3200", if_pc, imem_bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        tick();
        #3 reset = 0;
        #1;
        tests++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            fails++; $display("FAIL mid_rst_buf valid=%b pc=%h instr=%h want 0/0/0", if_valid, if_pc, if_instr); end
        tests++; if (imem_bus.imem_addr !== 32'h3000 || imem_bus.imem_req !== 1'b0) begin
            fails++; $display("FAIL mid_rst_pc addr=%h req=%b want 3000/0", imem_bus.imem_addr, imem_bus.imem_req); end
        #1 reset = 1;
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || imem_bus.imem_addr !== 32'h3004) begin
            fails++; $display("FAIL mid_rst_restart valid=%b pc=%h addr=%h want 1/3000/3004", if_valid, if_pc, imem_bus.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_beq_taken();
        test_beq_not_taken();
        test_jump();
        test_jr_squash();
        test_pending();
        test_stall_redirect();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
